llc_set_fetch: RTL and testbench

LLC_SET_FETCH -- requirements
Module: llc_set_fetch

---
 rtl/llc_set_fetch.sv | 111 +++++++++++
 tb/tb_llc_set_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_set_fetch.sv
// LLC set fetch: reads one set's tags/states, pushes a lookup packet,
// then strobes the lookup stage with a registered snapshot of the set.
module llc_set_fetch #(
    parameter int LLC_WAYS       = 16,
    parameter int LLC_WAY_BITS   = 4,
    parameter int LLC_SET_BITS   = 8,
    parameter int LLC_TAG_BITS   = 16,
    parameter int LLC_STATE_BITS = 3,
    parameter int INVALID        = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [LLC_SET_BITS-1:0]                req_set,
    input  logic [LLC_TAG_BITS-1:0]                req_tag,
    output logic                                   rd_en,
    output logic [LLC_SET_BITS-1:0]                rd_set,
    input  logic [LLC_WAYS*LLC_TAG_BITS-1:0]       rd_tags,
    input  logic [LLC_WAYS*LLC_STATE_BITS-1:0]     rd_states,
    input  logic [LLC_WAY_BITS-1:0]                rd_evict_way,
    input  logic                                   wr_en,
    input  logic [LLC_SET_BITS-1:0]                wr_set,
    input  logic [LLC_WAY_BITS-1:0]                wr_way,
    input  logic [LLC_TAG_BITS-1:0]                wr_tag,
    input  logic [LLC_STATE_BITS-1:0]              wr_state,
    output logic [LLC_WAYS*LLC_TAG_BITS-1:0]       tags_buf,
    output logic [LLC_WAYS*LLC_STATE_BITS-1:0]     states_buf,
    output logic [LLC_WAY_BITS-1:0]                evict_way_buf,
    output logic                                   fifo_push_lookup,
    output logic [LLC_TAG_BITS+LLC_SET_BITS-1:0]   fifo_lookup_in,
    input  logic                                   fifo_full_lookup,
    output logic                                   lookup_en,
    input  logic                                   lookup_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_ISSUE
    } state_t;

    state_t state, next_state;

    logic [LLC_SET_BITS-1:0] set_q;
    logic [LLC_TAG_BITS-1:0] tag_q;
    logic                    accept;
    logic                    fwd;

    assign accept = (state == S_IDLE) && req_valid && !fifo_full_lookup && !rst;
    assign fwd    = (state != S_IDLE) && wr_en && (wr_set == set_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_RD;
            S_RD:    next_state = S_ISSUE;
            S_ISSUE: if (!lookup_stall) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready        = (state == S_IDLE) && !fifo_full_lookup && !rst;
        rd_en            = accept;
        rd_set           = req_set;
        fifo_push_lookup = (state == S_RD);
        fifo_lookup_in   = {tag_q, set_q};
        lookup_en        = (state == S_ISSUE) && !lookup_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            set_q <= req_set;
            tag_q <= req_tag;
        end
    end

    // Same-set writes patch the snapshot; in RD they win over the SRAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_buf      <= '0;
            states_buf    <= {LLC_WAYS{LLC_STATE_BITS'(INVALID)}};
            evict_way_buf <= '0;
        end else begin
            if (state == S_RD) begin
                tags_buf      <= rd_tags;
                states_buf    <= rd_states;
                evict_way_buf <= rd_evict_way;
            end
            for (int w = 0; w < LLC_WAYS; w++) begin
                if (fwd && wr_way == LLC_WAY_BITS'(w)) begin
                    tags_buf[w*LLC_TAG_BITS +: LLC_TAG_BITS]       <= wr_tag;
                    states_buf[w*LLC_STATE_BITS +: LLC_STATE_BITS] <= wr_state;
                end
            end
        end
    end

endmodule

// File: tb/tb_llc_set_fetch.sv
// Bench for llc_set_fetch: directed and randomized requests checked
// against a per-way snapshot model of the expected buffers.
module tb_llc_set_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_set;
    logic [15:0]  req_tag;
    logic         rd_en;
    logic [7:0]   rd_set;
    logic [255:0] rd_tags;
    logic [47:0]  rd_states;
    logic [3:0]   rd_evict_way;
    logic         wr_en;
    logic [7:0]   wr_set;
    logic [3:0]   wr_way;
    logic [15:0]  wr_tag;
    logic [2:0]   wr_state;
    logic [255:0] tags_buf;
    logic [47:0]  states_buf;
    logic [3:0]   evict_way_buf;
    logic         fifo_push_lookup;
    logic [23:0]  fifo_lookup_in;
    logic         fifo_full_lookup;
    logic         lookup_en;
    logic         lookup_stall;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_tags[16];
    logic [2:0]  m_states[16];
    logic [3:0]  m_evict;

    llc_set_fetch dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_set(req_set),
        .req_tag(req_tag),
        .rd_en(rd_en),
        .rd_set(rd_set),
        .rd_tags(rd_tags),
        .rd_states(rd_states),
        .rd_evict_way(rd_evict_way),
        .wr_en(wr_en),
        .wr_set(wr_set),
        .wr_way(wr_way),
        .wr_tag(wr_tag),
        .wr_state(wr_state),
        .tags_buf(tags_buf),
        .states_buf(states_buf),
        .evict_way_buf(evict_way_buf),
        .fifo_push_lookup(fifo_push_lookup),
        .fifo_lookup_in(fifo_lookup_in),
        .fifo_full_lookup(fifo_full_lookup),
        .lookup_en(lookup_en),
        .lookup_stall(lookup_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_tags[i]   = '0;
            m_states[i] = '0;
        end
        m_evict = '0;
    endtask

    task automatic chk_bufs(input string tag);
        logic [255:0] et;
        logic [47:0]  es;
        for (int i = 0; i < 16; i++) begin
            et[i*16 +: 16] = m_tags[i];
            es[i*3 +: 3]   = m_states[i];
        end
        chk({tag, "_tags"}, tags_buf, et);
        chk({tag, "_states"}, {208'd0, states_buf}, {208'd0, es});
        chk({tag, "_evict"}, {252'd0, evict_way_buf}, {252'd0, m_evict});
    endtask

    task automatic rand_rd();
        for (int i = 0; i < 8; i++) rd_tags[i*32 +: 32] = $urandom;
        rd_states    = {$urandom, $urandom};
        rd_evict_way = 4'($urandom);
    endtask

    // One full request starting in IDLE; returns at the first IDLE cycle.
    task automatic run_req(input logic [7:0] s, input logic [15:0] t,
                           input int stall, input bit hit3,
                           input bit wr_rd, input logic [7:0] ws,
                           input logic [3:0] ww, input logic [15:0] wt,
                           input logic [2:0] wst, input bit wr_issue);
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = t;
        #2;
        chk("acc_ready", {255'd0, req_ready}, 256'd1);
        chk("acc_rd_en", {255'd0, rd_en}, 256'd1);
        chk("acc_rd_set", {248'd0, rd_set}, {248'd0, s});
        chk("acc_push", {255'd0, fifo_push_lookup}, 256'd0);
        step();
        req_valid = 1'b0;
        rand_rd();
        if (hit3) begin
            rd_tags[3*16 +: 16] = t;
            rd_states[3*3 +: 3] = 3'd1;
            rd_evict_way        = 4'd5;
        end
        for (int i = 0; i < 16; i++) begin
            m_tags[i]   = rd_tags[i*16 +: 16];
            m_states[i] = rd_states[i*3 +: 3];
        end
        m_evict = rd_evict_way;
        wr_en    = wr_rd;
        wr_set   = ws;
        wr_way   = ww;
        wr_tag   = wt;
        wr_state = wst;
        if (wr_rd && ws == s) begin
            m_tags[ww]   = wt;
            m_states[ww] = wst;
        end
        #2;
        chk("rd_push", {255'd0, fifo_push_lookup}, 256'd1);
        chk("rd_pkt", {232'd0, fifo_lookup_in}, {232'd0, t, s});
        chk("rd_ready", {255'd0, req_ready}, 256'd0);
        chk("rd_rd_en", {255'd0, rd_en}, 256'd0);
        chk("rd_lookup", {255'd0, lookup_en}, 256'd0);
        step();
        wr_en = 1'b0;
        rand_rd();
        for (int c = 0; c <= stall; c++) begin
            lookup_stall = (c < stall);
            if (wr_issue) begin
                wr_en    = 1'b1;
                wr_set   = ($urandom_range(0, 1) == 0) ? s : 8'($urandom);
                wr_way   = 4'($urandom);
                wr_tag   = 16'($urandom);
                wr_state = 3'($urandom);
            end
            #2;
            chk_bufs("issue");
            chk("issue_push", {255'd0, fifo_push_lookup}, 256'd0);
            chk("issue_ready", {255'd0, req_ready}, 256'd0);
            chk("issue_lookup", {255'd0, lookup_en}, {255'd0, c == stall});
            if (wr_en && wr_set == s) begin
                m_tags[wr_way]   = wr_tag;
                m_states[wr_way] = wr_state;
            end
            step();
            wr_en = 1'b0;
        end
        lookup_stall = 1'b0;
        #2;
        chk("idle_lookup", {255'd0, lookup_en}, 256'd0);
        chk("idle_ready", {255'd0, req_ready}, 256'd1);
        chk_bufs("idle");
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1;
        req_set = 8'h12;
        req_tag = 16'h1;
        rd_tags = '0;
        rd_states = '0;
        rd_evict_way = '0;
        wr_en = 1'b0;
        wr_set = '0;
        wr_way = '0;
        wr_tag = '0;
        wr_state = '0;
        fifo_full_lookup = 1'b0;
        lookup_stall = 1'b0;
        model_clear();
        #3;
        chk("rst_rd_en", {255'd0, rd_en}, 256'd0);
        chk("rst_ready", {255'd0, req_ready}, 256'd0);
        chk("rst_push", {255'd0, fifo_push_lookup}, 256'd0);
        chk("rst_lookup", {255'd0, lookup_en}, 256'd0);
        chk_bufs("rst");
        step();
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        #2;
        chk("post_rst_ready", {255'd0, req_ready}, 256'd1);

        // Basic hit-way request with evict pointer 5, back-to-back.
        run_req(8'h12, 16'hABCD, 0, 1'b1, 1'b0, 8'h0, 4'h0, 16'h0, 3'h0, 1'b0);
        chk("evict5", {252'd0, evict_way_buf}, 256'd5);
        run_req(8'h40, 16'h1234, 0, 1'b0, 1'b0, 8'h0, 4'h0, 16'h0, 3'h0, 1'b0);

        // Lookup FIFO full holds off acceptance.
        fifo_full_lookup = 1'b1;
        req_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("full_ready", {255'd0, req_ready}, 256'd0);
            chk("full_rd_en", {255'd0, rd_en}, 256'd0);
            step();
        end
        fifo_full_lookup = 1'b0;
        run_req(8'h21, 16'h5555, 4, 1'b0, 1'b0, 8'h0, 4'h0, 16'h0, 3'h0, 1'b0);

        // Forwarding in RD: same set patches way 7, other set ignored.
        run_req(8'h12, 16'hABCD, 0, 1'b0, 1'b1, 8'h12, 4'd7, 16'h1111, 3'd0, 1'b0);
        chk("fwd_tag7", {240'd0, tags_buf[7*16 +: 16]}, 256'h1111);
        chk("fwd_state7", {253'd0, states_buf[7*3 +: 3]}, 256'd0);
        run_req(8'h12, 16'hABCD, 0, 1'b0, 1'b1, 8'h13, 4'd7, 16'h1111, 3'd0, 1'b0);

        // Writes in IDLE leave the snapshot alone.
        wr_en = 1'b1;
        wr_set = 8'h12;
        wr_way = 4'd2;
        wr_tag = 16'hBEEF;
        wr_state = 3'd6;
        step();
        wr_en = 1'b0;
        #2;
        chk_bufs("idle_wr");
        step();

        // Reset during RD aborts the request.
        req_valid = 1'b1;
        req_set = 8'h77;
        req_tag = 16'h7777;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        model_clear();
        #2;
        chk("abort_push", {255'd0, fifo_push_lookup}, 256'd0);
        chk_bufs("abort");
        step();
        rst = 1'b0;
        #2;
        chk("abort_lookup", {255'd0, lookup_en}, 256'd0);
        chk("abort_ready", {255'd0, req_ready}, 256'd1);
        chk("abort_push2", {255'd0, fifo_push_lookup}, 256'd0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] s;
            s = 8'($urandom);
            run_req(s, 16'($urandom), int'($urandom_range(0, 3)), 1'b0,
                    1'($urandom), ($urandom_range(0, 1) == 0) ? s : 8'($urandom),
                    4'($urandom), 16'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
